// File: rtl/axi4s_upsizer_if.sv
// AXI4-Stream signal bundle used on both sides of axi4s_upsizer.
// src drives the stream, dst consumes it and returns tready.
interface axi4_stream_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DEST_W = 4,
  parameter int unsigned USER_W = 4
);
  logic                tvalid;
  logic                tready;
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [DATA_W/8-1:0] tstrb;
  logic                tlast;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [USER_W-1:0]   tuser;

  modport src (
    output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    input  tready
  );

  modport dst (
    input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi4s_upsizer.sv
// 64-bit to 256-bit AXI4-Stream upsizer with zero-padded early close and 16-lane output parity.
// Optional input parity checker enabled by defining AXI4S_UPSIZER_PARITY_CHECK_EN.
module axi4s_upsizer #(
  parameter int unsigned SRC_DATA_WIDTH = 64,
  parameter int unsigned DST_DATA_WIDTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  axi4_stream_if.dst axis4_t2,
  axi4_stream_if.src axis4_t1,
  output logic       parity_err
);
  localparam int unsigned Ratio    = DST_DATA_WIDTH / SRC_DATA_WIDTH;
  localparam int unsigned SlotW    = $clog2(Ratio);
  localparam int unsigned SrcKeep  = SRC_DATA_WIDTH / 8;
  localparam int unsigned DstKeep  = DST_DATA_WIDTH / 8;
  localparam int unsigned SrcLanes = SRC_DATA_WIDTH / 16;
  localparam int unsigned DstLanes = DST_DATA_WIDTH / 16;
  localparam int unsigned IdW      = 4;

  typedef enum logic {StFill, StOut} state_e;

  state_e                    r_state;
  logic [SlotW-1:0]          r_slot;
  logic [DST_DATA_WIDTH-1:0] r_data;
  logic [DstKeep-1:0]        r_keep;
  logic [DstKeep-1:0]        r_strb;
  logic [IdW-1:0]            r_tid;
  logic [IdW-1:0]            r_tdest;
  logic                      r_last;
  logic                      r_ready_en;

  logic                      w_id_mismatch;
  logic                      w_stall;
  logic                      w_in_ready;
  logic                      w_in_fire;
  logic                      w_out_valid;
  logic                      w_out_fire;
  logic                      w_close;
  logic [DST_DATA_WIDTH-1:0] w_nxt_data;
  logic [DstKeep-1:0]        w_nxt_keep;
  logic [DstKeep-1:0]        w_nxt_strb;
  logic [DstLanes-1:0]       w_out_par;

  // Handshake: a tid/tdest change mid-word stalls the input while the partial word is flushed.
  always_comb begin
    w_out_valid   = (r_state == StOut);
    w_out_fire    = w_out_valid && axis4_t1.tready;
    w_id_mismatch = (r_slot != '0) &&
                    ((axis4_t2.tid != r_tid) || (axis4_t2.tdest != r_tdest));
    w_stall       = (r_state == StFill) && axis4_t2.tvalid && w_id_mismatch;
    w_in_ready    = 1'b0;
    if (r_ready_en) begin
      if (r_state == StFill) begin
        w_in_ready = !w_stall;
      end else begin
        w_in_ready = axis4_t1.tready;
      end
    end
    w_in_fire = axis4_t2.tvalid && w_in_ready;
    w_close   = axis4_t2.tlast || (r_slot == SlotW'(Ratio - 1));
    axis4_t2.tready = w_in_ready;
  end

  // Starting a new word clears the buffer so unfilled slots read back as zero.
  always_comb begin
    w_nxt_data = (r_slot == '0) ? '0 : r_data;
    w_nxt_keep = (r_slot == '0) ? '0 : r_keep;
    w_nxt_strb = (r_slot == '0) ? '0 : r_strb;
    w_nxt_data[SRC_DATA_WIDTH*r_slot +: SRC_DATA_WIDTH] = axis4_t2.tdata;
    w_nxt_keep[SrcKeep*r_slot +: SrcKeep]               = axis4_t2.tkeep;
    w_nxt_strb[SrcKeep*r_slot +: SrcKeep]               = axis4_t2.tstrb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StFill;
      r_slot     <= '0;
      r_data     <= '0;
      r_keep     <= '0;
      r_strb     <= '0;
      r_tid      <= '0;
      r_tdest    <= '0;
      r_last     <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_in_fire) begin
        r_data <= w_nxt_data;
        r_keep <= w_nxt_keep;
        r_strb <= w_nxt_strb;
        if (r_slot == '0) begin
          r_tid   <= axis4_t2.tid;
          r_tdest <= axis4_t2.tdest;
        end
        // In StOut an accepted beat always lands in slot 0 of the next word.
        if (w_close) begin
          r_state <= StOut;
          r_last  <= axis4_t2.tlast;
          r_slot  <= '0;
        end else begin
          r_state <= StFill;
          r_slot  <= r_slot + 1'b1;
        end
      end else if (w_out_fire) begin
        r_state <= StFill;
        r_slot  <= '0;
      end else if (w_stall) begin
        r_state <= StOut;
        r_last  <= 1'b0;
        r_slot  <= '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DstLanes; i++) begin
      w_out_par[i] = ^r_data[16*i +: 16];
    end
    axis4_t1.tvalid = w_out_valid;
    axis4_t1.tdata  = w_out_valid ? r_data    : '0;
    axis4_t1.tkeep  = w_out_valid ? r_keep    : '0;
    axis4_t1.tstrb  = w_out_valid ? r_strb    : '0;
    axis4_t1.tlast  = w_out_valid && r_last;
    axis4_t1.tid    = w_out_valid ? r_tid     : '0;
    axis4_t1.tdest  = w_out_valid ? r_tdest   : '0;
    axis4_t1.tuser  = w_out_valid ? w_out_par : '0;
  end

`ifdef AXI4S_UPSIZER_PARITY_CHECK_EN
  logic [SrcLanes-1:0] w_in_par;
  logic                r_parity_err;

  always_comb begin
    for (int i = 0; i < SrcLanes; i++) begin
      w_in_par[i] = ^axis4_t2.tdata[16*i +: 16];
    end
  end

  // Sticky until reset; data is forwarded untouched regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_in_fire && (w_in_par != axis4_t2.tuser)) begin
      r_parity_err <= 1'b1;
      $error("axi4s_upsizer: input parity mismatch tuser=%h computed=%h",
             axis4_t2.tuser, w_in_par);
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi4s_upsizer.sv
// Self-checking bench for axi4s_upsizer: randomized streams compared against a word-grouping model.
module tb_axi4s_upsizer;
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic [3:0]  tid;
    logic [3:0]  tdest;
    logic [3:0]  user;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [31:0]  strb;
    logic [3:0]   tid;
    logic [3:0]   tdest;
    logic [15:0]  user;
    logic         last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  logic parity_err;

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_W(64),  .ID_W(4), .DEST_W(4), .USER_W(4))  s_if ();
  axi4_stream_if #(.DATA_W(256), .ID_W(4), .DEST_W(4), .USER_W(16)) m_if ();

  axi4s_upsizer #(
    .SRC_DATA_WIDTH(64),
    .DST_DATA_WIDTH(256)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axis4_t2  (s_if),
    .axis4_t1  (m_if),
    .parity_err(parity_err)
  );

  int    checks   = 0;
  int    failures = 0;
  beat_t in_q[$];
  word_t exp_q[$];
  word_t got_q[$];
  int    in_cyc[$];
  int    out_cyc[$];
  logic  tr_oval[$];
  word_t tr_word[$];
  logic  tr_ival[$];
  logic  tr_iready[$];

  function automatic logic [3:0] par4(input logic [63:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  function automatic logic [15:0] par16(input logic [255:0] d);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic beat_t mk_beat(input logic [63:0] d, input logic [3:0] tid,
                                    input logic [3:0] tdest, input logic last,
                                    input logic [7:0] keep);
    beat_t b;
    b.data  = d;
    b.keep  = keep;
    b.strb  = keep;
    b.tid   = tid;
    b.tdest = tdest;
    b.user  = par4(d);
    b.last  = last;
    return b;
  endfunction

  // Reference: group beats into words of up to 4, closing on tlast, on a full word,
  // or (with last=0) when a beat's tid/tdest differs from the open word's.
  function automatic void build_expected();
    word_t cur;
    beat_t b;
    int    n;
    exp_q.delete();
    cur = '0;
    n   = 0;
    foreach (in_q[i]) begin
      b = in_q[i];
      if (n > 0 && (b.tid != cur.tid || b.tdest != cur.tdest)) begin
        cur.last = 1'b0;
        cur.user = par16(cur.data);
        exp_q.push_back(cur);
        n = 0;
      end
      if (n == 0) begin
        cur       = '0;
        cur.tid   = b.tid;
        cur.tdest = b.tdest;
      end
      cur.data[64*n +: 64] = b.data;
      cur.keep[8*n +: 8]   = b.keep;
      cur.strb[8*n +: 8]   = b.strb;
      n++;
      if (n == 4 || b.last) begin
        cur.last = b.last;
        cur.user = par16(cur.data);
        exp_q.push_back(cur);
        n = 0;
      end
    end
  endfunction

  function automatic word_t sample_out();
    word_t w;
    w.data  = m_if.tdata;
    w.keep  = m_if.tkeep;
    w.strb  = m_if.tstrb;
    w.tid   = m_if.tid;
    w.tdest = m_if.tdest;
    w.user  = m_if.tuser;
    w.last  = m_if.tlast;
    return w;
  endfunction

  task automatic drive_beat(input beat_t b);
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.data;
    s_if.tkeep  = b.keep;
    s_if.tstrb  = b.strb;
    s_if.tid    = b.tid;
    s_if.tdest  = b.tdest;
    s_if.tuser  = b.user;
    s_if.tlast  = b.last;
  endtask

  task automatic drive_idle();
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tstrb  = '0;
    s_if.tid    = '0;
    s_if.tdest  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
  endtask

  // Streams in_q into the DUT; output tready is held low for the first `hold` cycles.
  task automatic run_stream(input int gap_pct, input int stall_pct, input int hold,
                            input int max_cyc, output int ready_low, output bit timeout);
    int idx;
    int c;
    bit pend;
    idx = 0;
    c = 0;
    pend = 1'b0;
    ready_low = 0;
    got_q.delete(); in_cyc.delete(); out_cyc.delete();
    tr_oval.delete(); tr_word.delete(); tr_ival.delete(); tr_iready.delete();
    while ((idx < in_q.size() || got_q.size() < exp_q.size()) && c < max_cyc) begin
      @(negedge clk);
      if (idx < in_q.size() && (pend || $urandom_range(99) >= gap_pct)) begin
        drive_beat(in_q[idx]);
        pend = 1'b1;
      end else begin
        drive_idle();
      end
      m_if.tready = (c >= hold) && ($urandom_range(99) >= stall_pct);
      #1;
      tr_oval.push_back(m_if.tvalid);
      tr_word.push_back(sample_out());
      tr_ival.push_back(s_if.tvalid);
      tr_iready.push_back(s_if.tready);
      if (s_if.tvalid && !s_if.tready) ready_low++;
      if (s_if.tvalid && s_if.tready) begin
        in_cyc.push_back(c);
        idx++;
        pend = 1'b0;
      end
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back(sample_out());
        out_cyc.push_back(c);
      end
      c++;
    end
    timeout = (idx < in_q.size()) || (got_q.size() < exp_q.size());
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_if.tready = 1'b1;
      #1;
      if (m_if.tvalid) got_q.push_back(sample_out());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    m_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      failures++; $display("FAIL reset_tvalid got=%b exp=0", m_if.tvalid);
    end
    checks++;
    if (m_if.tdata !== '0 || m_if.tkeep !== '0 || m_if.tuser !== '0 || m_if.tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_fields data=%h keep=%h user=%h last=%b exp=all zero",
               m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast);
    end
    checks++;
    if (s_if.tready !== 1'b0) begin
      failures++; $display("FAIL reset_tready got=%b exp=0", s_if.tready);
    end
    checks++;
    if (parity_err !== 1'b0) begin
      failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (s_if.tready !== 1'b0) begin
      failures++; $display("FAIL release_tready_early got=%b exp=0", s_if.tready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 1'b1) begin
      failures++; $display("FAIL release_tready_late got=%b exp=1", s_if.tready);
    end
  endtask

  task automatic test_basic();
    int rl;
    bit to;
    logic [63:0]  r;
    logic [255:0] cat;
    in_q.delete();
    for (int k = 0; k < 4; k++) begin
      r = rnd64();
      in_q.push_back(mk_beat({r[63:8], 8'(k)}, 4'd2, 4'd0, k == 3, 8'hFF));
    end
    cat = {in_q[3].data, in_q[2].data, in_q[1].data, in_q[0].data};
    build_expected();
    run_stream(0, 0, 0, 100, rl, to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL basic_count got=%0d exp=1", got_q.size());
    end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        failures++; $display("FAIL basic_word got=%h exp=%h", got_q[0], exp_q[0]);
      end
      checks++;
      if (got_q[0].data !== cat || got_q[0].keep !== 32'hFFFF_FFFF || got_q[0].last !== 1'b1 ||
          got_q[0].tid !== 4'd2 || got_q[0].user !== par16(cat)) begin
        failures++;
        $display("FAIL basic_fields data=%h keep=%h last=%b tid=%h user=%h exp data=%h",
                 got_q[0].data, got_q[0].keep, got_q[0].last, got_q[0].tid, got_q[0].user, cat);
      end
    end
    if (out_cyc.size() >= 1 && in_cyc.size() == 4) begin
      checks++;
      if (out_cyc[0] - in_cyc[3] != 1) begin
        failures++; $display("FAIL basic_latency got=%0d exp=1", out_cyc[0] - in_cyc[3]);
      end
    end
  endtask

  task automatic test_early_last();
    int rl;
    bit to;
    logic [3:0] tid;
    tid = 4'($urandom_range(15));
    in_q.delete();
    in_q.push_back(mk_beat(rnd64(), tid, 4'd7, 1'b0, 8'hFF));
    in_q.push_back(mk_beat(rnd64(), tid, 4'd7, 1'b1, 8'hFF));
    build_expected();
    run_stream(0, 0, 0, 100, rl, to);
    checks++;
    if (to || got_q.size() != 1) begin
      failures++; $display("FAIL early_count got=%0d timeout=%b exp=1", got_q.size(), to);
    end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0] !== exp_q[0]) begin
        failures++; $display("FAIL early_word got=%h exp=%h", got_q[0], exp_q[0]);
      end
      checks++;
      if (got_q[0].keep !== 32'h0000_FFFF || got_q[0].data[255:128] !== '0 ||
          got_q[0].last !== 1'b1) begin
        failures++;
        $display("FAIL early_pad keep=%h upper=%h last=%b exp keep=0000ffff upper=0 last=1",
                 got_q[0].keep, got_q[0].data[255:128], got_q[0].last);
      end
    end
  endtask

  task automatic test_tid_switch();
    int rl;
    bit to;
    in_q.delete();
    in_q.push_back(mk_beat(rnd64(), 4'd1, 4'd0, 1'b0, 8'hFF));
    in_q.push_back(mk_beat(rnd64(), 4'd3, 4'd0, 1'b1, 8'hFF));
    build_expected();
    run_stream(0, 0, 0, 100, rl, to);
    checks++;
    if (to || got_q.size() != 2) begin
      failures++; $display("FAIL tid_count got=%0d timeout=%b exp=2", got_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL tid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() >= 2) begin
      checks++;
      if (got_q[0].keep !== 32'h0000_00FF || got_q[0].last !== 1'b0 || got_q[0].tid !== 4'd1 ||
          got_q[1].tid !== 4'd3) begin
        failures++;
        $display("FAIL tid_fields keep0=%h last0=%b tid0=%h tid1=%h exp 000000ff 0 1 3",
                 got_q[0].keep, got_q[0].last, got_q[0].tid, got_q[1].tid);
      end
    end
    checks++;
    if (rl != 1) begin failures++; $display("FAIL tid_stall got=%0d exp=1", rl); end
  endtask

  task automatic test_full_rate();
    int rl;
    bit to;
    in_q.delete();
    for (int k = 0; k < 12; k++) begin
      in_q.push_back(mk_beat(rnd64(), 4'd5, 4'd9, k == 11, 8'($urandom_range(255))));
    end
    build_expected();
    run_stream(0, 0, 0, 200, rl, to);
    checks++;
    if (to || got_q.size() != 3) begin
      failures++; $display("FAIL rate_count got=%0d timeout=%b exp=3", got_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rate_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (rl != 0) begin failures++; $display("FAIL rate_tready_low got=%0d exp=0", rl); end
    for (int i = 1; i < out_cyc.size(); i++) begin
      checks++;
      if (out_cyc[i] - out_cyc[i-1] != 4) begin
        failures++;
        $display("FAIL rate_spacing%0d got=%0d exp=4", i, out_cyc[i] - out_cyc[i-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int rl;
    bit to;
    int unstable;
    in_q.delete();
    for (int k = 0; k < 8; k++) begin
      in_q.push_back(mk_beat(rnd64(), 4'd4, 4'd2, k == 7, 8'hFF));
    end
    build_expected();
    run_stream(0, 0, 14, 200, rl, to);
    checks++;
    if (to || got_q.size() != 2) begin
      failures++; $display("FAIL bp_count got=%0d timeout=%b exp=2", got_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    unstable = 0;
    for (int c = 4; c < 14 && c < tr_oval.size(); c++) begin
      if (tr_oval[c] !== 1'b1 || tr_word[c] !== exp_q[0]) unstable++;
    end
    checks++;
    if (unstable != 0 || tr_oval.size() < 14) begin
      failures++; $display("FAIL bp_stable got=%0d bad cycles exp=0", unstable);
    end
    checks++;
    if (rl != 10) begin failures++; $display("FAIL bp_tready_low got=%0d exp=10", rl); end
  endtask

  task automatic test_random(input int rounds);
    int rl;
    bit to;
    int n;
    logic [3:0] tid;
    logic [3:0] tdest;
    for (int r = 0; r < rounds; r++) begin
      in_q.delete();
      n = 20 + $urandom_range(20);
      tid = 4'd0;
      tdest = 4'd0;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(99) < 20) tid = 4'($urandom_range(1));
        if ($urandom_range(99) < 10) tdest = 4'($urandom_range(1));
        in_q.push_back(mk_beat(rnd64(), tid, tdest,
                               (k == n - 1) || ($urandom_range(99) < 15),
                               8'($urandom_range(255))));
      end
      build_expected();
      run_stream(int'($urandom_range(40)), int'($urandom_range(50)), 0, 2000, rl, to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d timeout=%b exp=%0d", r, got_q.size(), to,
                 exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL rand%0d_word%0d got=%h exp=%h", r, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rl;
    bit to;
    int seen;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_beat(mk_beat(rnd64(), 4'd6, 4'd1, 1'b0, 8'hFF));
      m_if.tready = 1'b1;
    end
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || s_if.tready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_immediate tvalid=%b data=%h tready=%b exp 0 0 0",
               m_if.tvalid, m_if.tdata, s_if.tready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (m_if.tvalid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midrst_partial got=%0d exp=0", seen); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_beat(mk_beat(rnd64(), 4'd6, 4'd1, 1'b0, 8'hFF));
      m_if.tready = 1'b0;
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (m_if.tvalid !== 1'b1) begin
      failures++; $display("FAIL midrst_held got=%b exp=1", m_if.tvalid);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_if.tready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (m_if.tvalid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL midrst_unsent got=%0d exp=0", seen); end
    in_q.delete();
    for (int k = 0; k < 3; k++) in_q.push_back(mk_beat(rnd64(), 4'd8, 4'd3, k == 2, 8'hFF));
    build_expected();
    run_stream(0, 0, 0, 100, rl, to);
    checks++;
    if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL midrst_recover count=%0d timeout=%b exp count=1 word=%h",
               got_q.size(), to, exp_q[0]);
    end
  endtask

  task automatic test_parity();
    int rl;
    bit to;
    beat_t b;
    logic exp_err;
`ifdef AXI4S_UPSIZER_PARITY_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    in_q.delete();
    in_q.push_back(mk_beat(rnd64(), 4'd3, 4'd3, 1'b0, 8'hFF));
    b = mk_beat(rnd64(), 4'd3, 4'd3, 1'b1, 8'hFF);
    b.user[0] = ~b.user[0];
    in_q.push_back(b);
    build_expected();
    run_stream(0, 0, 0, 100, rl, to);
    checks++;
    if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL parity_passthrough count=%0d timeout=%b exp count=1 word=%h",
               got_q.size(), to, exp_q[0]);
    end
    checks++;
    if (parity_err !== exp_err) begin
      failures++; $display("FAIL parity_set got=%b exp=%b", parity_err, exp_err);
    end
    in_q.delete();
    for (int k = 0; k < 4; k++) in_q.push_back(mk_beat(rnd64(), 4'd1, 4'd1, k == 3, 8'hFF));
    build_expected();
    run_stream(0, 0, 0, 100, rl, to);
    checks++;
    if (parity_err !== exp_err) begin
      failures++; $display("FAIL parity_sticky got=%b exp=%b", parity_err, exp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (parity_err !== 1'b0) begin
      failures++; $display("FAIL parity_clear got=%b exp=0", parity_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_last();
    test_tid_switch();
    test_full_rate();
    test_backpressure();
    test_random(3);
    test_reset_mid();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4s_upsizer.md
AXI4S_UPSIZER -- requirements
Module: axi4s_upsizer

Interface
REQ-001 SHALL have parameter SRC_DATA_WIDTH, default 64: input beat width in bits; only 64 is supported.
REQ-002 SHALL have parameter DST_DATA_WIDTH, default 256: output beat width in bits; only 256 is supported; RATIO = DST/SRC = 4.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port axis4_t2  axi4_stream_if.dst  64-bit data, tkeep/tstrb 8, tid 4, tdest 4, tuser 4 (parity, one bit per 16-bit lane)  narrow input stream.
REQ-006 SHALL have port axis4_t1  axi4_stream_if.src  256-bit data, tkeep/tstrb 32, tid 4, tdest 4, tuser 16 (parity)  wide output stream.
REQ-007 SHALL have port parity_err  output  1  sticky input-parity error flag.

Function
REQ-008 SHALL have two states: FILL (accumulating) and OUT (holding a complete wide word).
REQ-009 SHALL place the narrow beat accepted at slot k (0..3) in output bits [64k +: 64], keep/strb bytes [8k +: 8]; slot 0 is least significant.
REQ-010 SHALL capture tid and tdest from the slot-0 beat.
REQ-011 SHALL transition FILL->OUT on acceptance of the slot-3 beat, or of any beat with tlast=1.
REQ-012 SHALL, on an early tlast, output the unfilled slots with data, keep and strb all zero.
REQ-013 SHALL, in FILL with slot>0, deassert axis4_t2.tready when the incoming tid or tdest differs from the captured values; this stall lasts one cycle.
REQ-014 SHALL, in that stall case, force the partial word to OUT with tlast=0 and zero-padded unfilled slots; the stalled beat becomes slot 0 of the next word.
REQ-015 SHALL assert axis4_t1.tvalid exactly when in OUT; latency is one cycle from the completing input beat to tvalid.
REQ-016 SHALL hold all axis4_t1 fields stable while tvalid=1 and tready=0.
REQ-017 SHALL drive all axis4_t1 fields to zero when tvalid=0.
REQ-018 SHALL drive axis4_t1.tlast high only when the word was closed by an input tlast.
REQ-019 SHALL compute axis4_t1.tuser[i] = XOR of tdata[16i +: 16] for i = 0..15, over the padded data.
REQ-020 SHALL drive axis4_t2.tready = 1 in FILL (except per REQ-013), and in OUT only in a cycle where axis4_t1 fires.
REQ-021 SHALL, when axis4_t1 fires and a narrow beat is accepted in the same cycle, load that beat into slot 0; this gives zero bubbles at full rate (4 in : 1 out).
REQ-022 SHALL, when axis4_t1 fires with no input beat, return to FILL at slot 0.

Reset
REQ-023 SHALL, while rst=1, immediately force state FILL, slot 0, every axis4_t1 field to 0, axis4_t2.tready to 0, and parity_err to 0.
REQ-024 SHALL discard a partially filled or unsent word when rst is asserted mid-operation.
REQ-025 SHALL assert axis4_t2.tready one cycle after rst deasserts.

Configuration
REQ-026 SHALL, with AXI4S_UPSIZER_PARITY_CHECK_EN defined, compare each accepted input tuser against a 4-lane 16-bit XOR of its tdata.
REQ-027 SHALL, on such a mismatch, set parity_err (held until reset) and issue a simulation $error; the data still passes through unchanged.
REQ-028 SHALL, without AXI4S_UPSIZER_PARITY_CHECK_EN, tie parity_err to 0 and include no checker logic.

Verification
REQ-029 SHALL cover this scenario: four beats 0x..00 to 0x..03 (tid=2, keep=0xFF, last on beat 4), output ready=1 -> one output beat, data = {b3,b2,b1,b0}, keep=0xFFFFFFFF, tlast=1, tid=2, tuser equals the computed 16-lane parity, one cycle after beat 4.
REQ-030 SHALL cover this scenario: two beats, tlast on beat 2 -> keep=0x0000FFFF, upper 128 data bits zero, tlast=1.
REQ-031 SHALL cover this scenario: beat 1 tid=1, beat 2 tid=3 -> output keep=0x000000FF, tlast=0, tid=1; the tid=3 beat starts the next word; tready low for exactly one cycle.
REQ-032 SHALL cover this scenario: continuous input, output ready=1 -> one output every 4 cycles, input tready never low.
REQ-033 SHALL cover this scenario: output ready held 0 for 10 cycles -> output fields stable; input tready low after the word completes.
REQ-034 SHALL cover this scenario: rst asserted after 2 beats, and (with the macro defined) one beat with flipped tuser[0] -> after reset no output from the discarded beats; parity_err=1 after the bad beat and still 1 until the next reset.
